aes_encrypt_core: RTL and testbench
===================================

Name: aes_encrypt_core

Overview:
Iterative AES-128 encryption core. It is the encrypt-side counterpart of the lab's AES decryption core and uses the same START/DONE handshake, so software or the Avalon wrapper can drive either core the same way. Per round it runs SubBytes, ShiftRows, MixColumns and AddRoundKey as separate sequenced steps over a single 128-bit state register. Round keys are expanded on chip into a local schedule.

Parameters:
MC_PER_CYCLE, 1, columns processed per MixColumns cycle; legal values 1 or 4 (4 = whole state in one cycle)

Ports:
CLK  input  1  single clock, all state on rising edge
RESET  input  1  asynchronous, active-low reset
AES_START  input  1  level request; sampled in IDLE
AES_DONE  output  1  result valid; held until AES_START is low
AES_KEY  input  128  cipher key; byte 0 = [127:120]
AES_MSG_DEC  input  128  plaintext; byte 0 = [127:120], column-major state
AES_MSG_ENC  output  128  ciphertext; held stable from DONE until next accepted START

Behaviour:
- Reset (RESET=0, async): FSM=IDLE; AES_DONE=0; AES_MSG_ENC=0; state, round counter, column counter and key schedule all cleared. Reset mid-operation aborts immediately with no partial output.
- IDLE: when AES_START=1 on an edge, latch AES_KEY and AES_MSG_DEC, then go to KEYEXP. Inputs are not re-sampled after that point.
- KEYEXP: 10 cycles. Each cycle computes round key i (i=1..10) from key i-1 using RotWord, SubWord and Rcon (01,02,04,08,10,20,40,80,1B,36). Results go into an 11x128 schedule, with key 0 = the latched key.
- ARK0: state = plaintext XOR key 0; round=1.
- SUB: 1 cycle. Applies the forward S-box to all 16 bytes.
- SHIFT: 1 cycle. Row r is rotated left by r bytes.
- MIX: 4/MC_PER_CYCLE cycles.
  - Column counter goes 0..3 (column 0 = [127:96]); GF(2^8) matrix [2 3 1 1], xtime reduction 0x1B.
  - Columns not being written are held.
  - Skipped when round==10.
- ARK: state ^= key[round]. If round==10, go to DONE and load AES_MSG_ENC. Otherwise round++ and go to SUB.
- DONE: AES_DONE=1. Return to IDLE on the first edge that samples AES_START=0; AES_DONE drops in that same cycle. AES_START held high keeps the FSM in DONE with no restart.
- AES_START falling during an operation is ignored; the operation completes, and DONE lasts 1 cycle if START is already low.
- Latency, from the START-sampling edge to the first cycle AES_DONE=1:
  - MC_PER_CYCLE=1: 10 + 1 + 9×7 + 3 = 77 edges.
  - MC_PER_CYCLE=4: 10 + 1 + 9×4 + 3 = 50 edges.
- Round counter is 4 bits and never exceeds 10. Column counter is 2 bits, wraps 3→0 and is cleared on entering MIX.
- AES_MSG_ENC changes only on the ARK→DONE transition.

Optional Feature:
AES_KEY_CACHE_EN
- Defined:
  - A 128-bit tag holds the key of the last completed expansion, plus a valid bit cleared by reset.
  - On START, if the tag is valid and AES_KEY equals the tag, KEYEXP is skipped. Latency then drops by 10 (67 / 40 edges).
  - A different key triggers full KEYEXP and updates the tag.
  - Reset mid-KEYEXP leaves the tag invalid.
- Undefined: no tag logic; KEYEXP always runs.

Test Plan:
1. FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> AES_MSG_ENC 69c4e0d86a7b0430d8cdb78070b4c55a; AES_DONE exactly 77 edges after START (50 with MC_PER_CYCLE=4).
2. FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32. Check internal key[10] = d014f9a8c9ee2589e13f0cc8b6630ca6 after KEYEXP.
3. Handshake: hold START high for 200 cycles -> AES_DONE stays 1 and output is stable. Drop START -> DONE falls next edge. Re-raise START -> new run.
4. Reset mid-run: assert RESET=0 at cycle 40 of a run -> AES_DONE=0 and AES_MSG_ENC=0 immediately. Release and start C.1 -> correct ciphertext.
5. Input change after start: alter AES_KEY and AES_MSG_DEC 1 cycle after START -> result still matches the values latched at START.
6. AES_KEY_CACHE_EN: run C.1 twice with the same key -> second DONE at 67 edges; switch to the B key -> 77 edges and the B result is correct.

Source files
------------

// File: rtl/aes_encrypt_core.sv
// aes_encrypt_core: iterative AES-128 encryptor, one round step per state, on-chip key schedule.
// Optional AES_KEY_CACHE_EN skips key expansion when the key matches the last expanded key.
module aes_encrypt_core #(
    parameter int MC_PER_CYCLE = 1
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         AES_START,
    output logic         AES_DONE,
    input  logic [127:0] AES_KEY,
    input  logic [127:0] AES_MSG_DEC,
    output logic [127:0] AES_MSG_ENC
);
    typedef enum logic [2:0] {S_IDLE, S_KEYEXP, S_ARK0, S_SUB, S_SHIFT, S_MIX, S_ARK, S_DONE} state_t;
    localparam logic [79:0] RCON = 80'h01020408102040801b36;

    state_t       r_fsm, w_next;
    logic [127:0] r_state, r_enc, w_sub, w_shift, w_mix, w_ark;
    logic [127:0] r_keys [0:10];
    logic [3:0]   r_round;
    logic [1:0]   r_col;
    logic         w_hit, w_mix_last;

    function automatic logic [7:0] f_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] f_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = f_xtime(x);
        end
        return p;
    endfunction

    // Inverse computed as a^254 (square-and-multiply over 0b11111110), then the affine map
    function automatic logic [7:0] f_sbox(input logic [7:0] a);
        logic [7:0] v;
        v = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            v = f_gmul(v, v);
            if (i != 0) v = f_gmul(v, a);
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] f_next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2;
        t  = {f_sbox(k[23:16]), f_sbox(k[15:8]), f_sbox(k[7:0]), f_sbox(k[31:24])} ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        return {n0, n1, n2, k[31:0] ^ n2};
    endfunction

    function automatic logic [31:0] f_mixcol(input logic [31:0] c);
        logic [7:0] b0, b1, b2, b3;
        {b0, b1, b2, b3} = c;
        return {f_xtime(b0) ^ f_xtime(b1) ^ b1 ^ b2 ^ b3,
                b0 ^ f_xtime(b1) ^ f_xtime(b2) ^ b2 ^ b3,
                b0 ^ b1 ^ f_xtime(b2) ^ f_xtime(b3) ^ b3,
                f_xtime(b0) ^ b0 ^ b1 ^ b2 ^ f_xtime(b3)};
    endfunction

    // Byte k = row k%4 of column k/4; ShiftRows takes row r from column (c+r)%4
    always_comb begin
        w_sub   = '0;
        w_shift = '0;
        w_mix   = r_state;
        for (int k = 0; k < 16; k++) begin
            w_sub[127-8*k -: 8]   = f_sbox(r_state[127-8*k -: 8]);
            w_shift[127-8*k -: 8] = r_state[127-8*(4*(((k/4)+(k%4))%4)+(k%4)) -: 8];
        end
        for (int c = 0; c < 4; c++)
            if (MC_PER_CYCLE == 4 || r_col == 2'(c)) w_mix[127-32*c -: 32] = f_mixcol(r_state[127-32*c -: 32]);
        w_ark      = r_state ^ r_keys[r_round];
        w_mix_last = MC_PER_CYCLE == 4 || r_col == 2'd3;
    end

`ifdef AES_KEY_CACHE_EN
    logic [127:0] r_tag;
    logic         r_tag_valid;
    assign w_hit = r_tag_valid && AES_KEY == r_tag;
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_tag       <= '0;
            r_tag_valid <= 1'b0;
        end else if (r_fsm == S_IDLE && AES_START && !w_hit) begin
            r_tag_valid <= 1'b0;
        end else if (r_fsm == S_KEYEXP && r_round == 4'd10) begin
            r_tag       <= r_keys[0];
            r_tag_valid <= 1'b1;
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) r_fsm <= S_IDLE;
        else        r_fsm <= w_next;
    end

    always_comb begin
        w_next = r_fsm;
        case (r_fsm)
            S_IDLE:   if (AES_START) w_next = w_hit ? S_ARK0 : S_KEYEXP;
            S_KEYEXP: if (r_round == 4'd10) w_next = S_ARK0;
            S_ARK0:   w_next = S_SUB;
            S_SUB:    w_next = S_SHIFT;
            S_SHIFT:  w_next = r_round == 4'd10 ? S_ARK : S_MIX;
            S_MIX:    if (w_mix_last) w_next = S_ARK;
            S_ARK:    w_next = r_round == 4'd10 ? S_DONE : S_SUB;
            S_DONE:   if (!AES_START) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        AES_DONE    = r_fsm == S_DONE;
        AES_MSG_ENC = r_enc;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= '0;
            r_enc   <= '0;
            r_round <= '0;
            r_col   <= '0;
            for (int k = 0; k < 11; k++) r_keys[k] <= '0;
        end else begin
            case (r_fsm)
                S_IDLE: if (AES_START) begin
                    r_state   <= AES_MSG_DEC;
                    r_keys[0] <= AES_KEY;
                    r_round   <= 4'd1;
                end
                S_KEYEXP: begin
                    r_keys[r_round] <= f_next_key(r_keys[4'(r_round - 4'd1)], RCON[8*(10-int'(r_round)) +: 8]);
                    if (r_round != 4'd10) r_round <= r_round + 4'd1;
                end
                S_ARK0: begin
                    r_state <= r_state ^ r_keys[0];
                    r_round <= 4'd1;
                end
                S_SUB:   r_state <= w_sub;
                S_SHIFT: begin
                    r_state <= w_shift;
                    r_col   <= 2'd0;
                end
                S_MIX: begin
                    r_state <= w_mix;
                    r_col   <= r_col + 2'd1;
                end
                S_ARK: begin
                    r_state <= w_ark;
                    if (r_round == 4'd10) r_enc <= w_ark;
                    else                  r_round <= r_round + 4'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_encrypt_core.sv
// tb_aes_encrypt_core: FIPS-197 vectors plus random runs against a byte-array AES model,
// with latency, handshake, reset-abort and (if AES_KEY_CACHE_EN) key-cache checks.
module tb_aes_encrypt_core;
    localparam int MC = 1;
    localparam int BASE_LAT = 10 + 1 + 9 * (3 + 4 / MC) + 3;
`ifdef AES_KEY_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic         AES_START = 1'b0;
    logic         AES_DONE;
    logic [127:0] AES_KEY = '0;
    logic [127:0] AES_MSG_DEC = '0;
    logic [127:0] AES_MSG_ENC;

    int           n_chk = 0;
    int           n_fail = 0;
    logic [7:0]   sbox [256];
    bit           c_valid = 1'b0;
    logic [127:0] c_key = '0;

    aes_encrypt_core #(.MC_PER_CYCLE(MC)) dut (
        .CLK(CLK), .RESET(RESET), .AES_START(AES_START), .AES_DONE(AES_DONE),
        .AES_KEY(AES_KEY), .AES_MSG_DEC(AES_MSG_DEC), .AES_MSG_ENC(AES_MSG_ENC)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    endfunction

    // S-box table walked via generator 3 and its inverse, then the affine map
    task automatic build_sbox();
        logic [7:0] p, q;
        p = 8'h01;
        q = 8'h01;
        for (int n = 0; n < 255; n++) begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            sbox[p] = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
        end
        sbox[0] = 8'h63;
    endtask

    function automatic logic [127:0] ref_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [31:0]  x;
        logic [127:0] o;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            x = w[i-1];
            if (i % 4 == 0) begin
                x = {sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]], sbox[x[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ x;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) s[4*c+row] = t[4*((c+row)%4)+row];
            if (r < 10)
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One full transaction; exp_ct < 0 style override via has_exp lets FIPS vectors pin the answer
    task automatic run(input string tag, input logic [127:0] key, input logic [127:0] pt,
                       input bit has_exp, input logic [127:0] exp_in,
                       input bit perturb, input bit drop_early, input int hold);
        logic [127:0] exp_ct;
        int           exp_lat, lat, stable;
        exp_ct  = has_exp ? exp_in : ref_enc(key, pt);
        exp_lat = (CACHE && c_valid && key == c_key) ? BASE_LAT - 10 : BASE_LAT;
        @(negedge CLK);
        AES_KEY     = key;
        AES_MSG_DEC = pt;
        AES_START   = 1'b1;
        @(posedge CLK);
        lat = 0;
        while (lat < 300) begin
            @(posedge CLK);
            lat++;
            #1;
            if (perturb && lat == 1) begin
                AES_KEY     = rnd128();
                AES_MSG_DEC = rnd128();
            end
            if (drop_early && lat == 3) AES_START = 1'b0;
            if (AES_DONE) break;
        end
        check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
        check({tag, "_ct"}, AES_MSG_ENC, exp_ct);
        c_valid = 1'b1;
        c_key   = key;
        if (hold > 0) begin
            stable = 0;
            repeat (hold) begin
                @(posedge CLK);
                #1;
                if (AES_DONE && AES_MSG_ENC === exp_ct) stable++;
            end
            check({tag, "_hold"}, 128'(stable), 128'(hold));
        end
        if (!drop_early) begin
            @(negedge CLK);
            AES_START = 1'b0;
        end
        @(posedge CLK);
        #1;
        check({tag, "_done_fall"}, 128'(AES_DONE), 128'(0));
    endtask

    task automatic reset_mid(input string tag, input int cycles, input logic [127:0] key);
        @(negedge CLK);
        AES_KEY     = key;
        AES_MSG_DEC = rnd128();
        AES_START   = 1'b1;
        repeat (cycles) @(posedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        check({tag, "_done"}, 128'(AES_DONE), 128'(0));
        check({tag, "_ct"}, AES_MSG_ENC, 128'h0);
        AES_START = 1'b0;
        c_valid   = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    initial begin
        logic [127:0] k;
        build_sbox();
        #12;
        check("reset_done", 128'(AES_DONE), 128'(0));
        check("reset_ct", AES_MSG_ENC, 128'h0);
        @(negedge CLK);
        RESET = 1'b1;

        run("c1", 128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
            1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, 1'b0, 0);
        run("c1_again", 128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
            1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, 1'b0, 0);
        run("fips_b", 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
            1'b1, 128'h3925841d02dc09fbdc118597196a0b32, 1'b0, 1'b0, 0);
        check("fips_b_key10", dut.r_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        run("hold", rnd128(), rnd128(), 1'b0, '0, 1'b0, 1'b0, 200);
        run("restart", rnd128(), rnd128(), 1'b0, '0, 1'b0, 1'b0, 0);
        run("perturb", rnd128(), rnd128(), 1'b0, '0, 1'b1, 1'b0, 0);
        run("drop_early", rnd128(), rnd128(), 1'b0, '0, 1'b0, 1'b1, 0);

        reset_mid("rst40", 40, 128'h000102030405060708090a0b0c0d0e0f);
        run("c1_post_rst", 128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
            1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, 1'b0, 0);
        k = rnd128();
        reset_mid("rst_kexp", 5, k);
        run("after_kexp_rst", k, rnd128(), 1'b0, '0, 1'b0, 1'b0, 0);

        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 0) k = rnd128();
            run("rand", k, rnd128(), 1'b0, '0, 1'b0, 1'b0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
